// File: rtl/seq_pattern_tx_if.sv
// Handshake and data bundle for the serial pattern transmitter.
// Master drives the request side, slave produces the serial stream.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output abort,
    output pattern,
    output repeat_cnt,
    output gap_len,
    input  out,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  pattern,
    input  repeat_cnt,
    input  gap_len,
    output out,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeated repeat_cnt times with gap_len idle cycles between repeats.
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input logic           clk,
  input logic           reset,
  seq_pattern_tx_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pat, pat_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic [GAP_W-1:0] gap_cfg, gap_cfg_d;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_d;
  logic [IW-1:0]    bit_idx, bit_idx_d;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pat     <= '0;
      rem     <= '0;
      gap_cfg <= '0;
      gap_cnt <= '0;
      bit_idx <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      pat     <= pat_d;
      rem     <= rem_d;
      gap_cfg <= gap_cfg_d;
      gap_cnt <= gap_cnt_d;
      bit_idx <= bit_idx_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs are the registered image of the state being processed,
  // so each SEND cycle's bit appears one edge after the state is entered.
  always_comb begin
    state_d   = state;
    pat_d     = pat;
    rem_d     = rem;
    gap_cfg_d = gap_cfg;
    gap_cnt_d = gap_cnt;
    bit_idx_d = bit_idx;
    out_d     = 1'b0;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.repeat_cnt != '0) begin
            pat_d     = bus.pattern;
            rem_d     = bus.repeat_cnt;
            gap_cfg_d = bus.gap_len;
            bit_idx_d = LAST;
            state_d   = SEND;
          end else begin
            state_d   = DONE;
          end
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          out_d  = pat[bit_idx];
          vld_d  = 1'b1;
          busy_d = 1'b1;
          if (bit_idx == '0) begin
            rem_d = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
              state_d = DONE;
            end else if (gap_cfg == '0) begin
              bit_idx_d = LAST;
            end else begin
              gap_cnt_d = gap_cfg;
              state_d   = GAP;
            end
          end else begin
            bit_idx_d = bit_idx - IW'(1);
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            gap_cnt_d = '0;
            bit_idx_d = LAST;
            state_d   = SEND;
          end else begin
            gap_cnt_d = gap_cnt - GAP_W'(1);
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus queues expected
// per-cycle events, a negedge monitor pops and compares them.
module tb_seq_pattern_tx;

  localparam int W  = 4;
  localparam int CW = 4;
  localparam int GW = 4;

  localparam logic [2:0] C_BIT = 3'b011;
  localparam logic [2:0] C_GAP = 3'b010;
  localparam logic [2:0] C_DN  = 3'b100;

  typedef struct packed {
    logic [2:0] code;
    logic       b;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  seq_pattern_tx_if #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) bus ();

  seq_pattern_tx #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ev_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cyc = -1;
  int ev_cnt = 0;
  int det_cnt = 0;
  logic [3:0] sr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: classify each cycle as bit / gap / done and match the queue
  always @(negedge clk) begin : mon
    logic [2:0] code;
    ev_t e;
    code = {bus.done, bus.busy, bus.out_valid};
    if (code != 3'b000) begin
      ev_cnt++;
      if (q.size() == 0) begin
        chk("unexpected_output", int'(code), 0);
      end else begin
        e = q.pop_front();
        chk("event_kind", int'(code), int'(e.code));
        if (bus.out_valid) chk("out_bit", int'(bus.out), int'(e.b));
        else chk("out_idle_zero", int'(bus.out), 0);
      end
      if (bus.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        sr = {sr[2:0], bus.out};
        if (sr == 4'hF) det_cnt++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        sr = '0;
      end
    end
  end

  task automatic clr_trk();
    first_cyc = -1;
    last_cyc  = -1;
    done_cyc  = -1;
    det_cnt   = 0;
  endtask

  task automatic push_burst(input logic [3:0] p, input int r, input int g);
    for (int rep = 0; rep < r; rep++) begin
      for (int i = 3; i >= 0; i--) q.push_back('{code: C_BIT, b: p[i]});
      if (rep < r - 1)
        for (int k = 0; k < g; k++) q.push_back('{code: C_GAP, b: 1'b0});
    end
    q.push_back('{code: C_DN, b: 1'b0});
  endtask

  // issue a burst at the current negedge and check its timing
  task automatic run(input string nm, input logic [3:0] p, input int r,
                     input int g, input int extra_at, input logic ab);
    int s, n, len;
    clr_trk();
    bus.pattern    = p;
    bus.repeat_cnt = CW'(r);
    bus.gap_len    = GW'(g);
    bus.abort      = ab;
    bus.start      = 1'b1;
    s = cyc + 1;
    push_burst(p, r, g);
    @(negedge clk);
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pattern    = ~p;
    bus.repeat_cnt = '1;
    bus.gap_len    = 4'h7;
    if (extra_at > 0) begin
      while (cyc < s + extra_at) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (done_cyc < 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, int'(done_cyc >= 0), 1);
    @(negedge clk);
    if (r > 0) begin
      len = r * W + (r - 1) * g;
      chk({nm, "_first_bit_cyc"}, first_cyc, s + 1);
      chk({nm, "_last_bit_cyc"}, last_cyc, s + len);
      chk({nm, "_done_cyc"}, done_cyc, s + len + 1);
    end else begin
      chk({nm, "_no_bits"}, first_cyc, -1);
      chk({nm, "_done_cyc"}, done_cyc, s + 1);
    end
    chk({nm, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s, ev0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    bus.gap_len    = '0;
    repeat (2) @(negedge clk);
    chk("reset_state",
        int'({bus.out, bus.out_valid, bus.busy, bus.done}), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run("single", 4'b1011, 1, 0, 0, 1'b0);

    run("b2b", 4'b1111, 3, 0, 0, 1'b0);
    chk("b2b_span", last_cyc - first_cyc + 1, 12);
    chk("b2b_detections", det_cnt, 9);

    run("gap", 4'b1101, 2, 3, 2, 1'b0);
    chk("gap_span", last_cyc - first_cyc + 1, 11);

    run("zero_rep", 4'b1011, 0, 2, 0, 1'b0);

    run("max_rep", 4'b1001, 15, 0, 0, 1'b0);

    // abort in the second repetition: 1010, one gap cycle, then bit 1
    clr_trk();
    bus.pattern    = 4'b1010;
    bus.repeat_cnt = 4'd5;
    bus.gap_len    = 4'd1;
    bus.start      = 1'b1;
    s = cyc + 1;
    q.push_back('{code: C_BIT, b: 1'b1});
    q.push_back('{code: C_BIT, b: 1'b0});
    q.push_back('{code: C_BIT, b: 1'b1});
    q.push_back('{code: C_BIT, b: 1'b0});
    q.push_back('{code: C_GAP, b: 1'b0});
    q.push_back('{code: C_BIT, b: 1'b1});
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s + 6) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.out_valid), 0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cyc, -1);
    chk("abort_queue_empty", q.size(), 0);

    run("post_abort", 4'b1010, 2, 1, 0, 1'b1);

    // asynchronous reset between edges in the middle of a burst
    clr_trk();
    bus.pattern    = 4'b1011;
    bus.repeat_cnt = 4'd3;
    bus.gap_len    = 4'd2;
    bus.start      = 1'b1;
    s = cyc + 1;
    push_burst(4'b1011, 3, 2);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s + 3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_out", int'(bus.out), 0);
    chk("areset_valid", int'(bus.out_valid), 0);
    chk("areset_busy", int'(bus.busy), 0);
    chk("areset_done", int'(bus.done), 0);
    q.delete();
    done_cyc = -1;
    ev0 = ev_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("areset_quiet", ev_cnt - ev0, 0);
    chk("areset_no_done", done_cyc, -1);

    run("recover", 4'b0110, 2, 2, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
